// File: rtl/cfs_rx_ctrl.sv
// rtl/cfs_rx_ctrl.sv - MD RX legality check, RX FIFO push and saturating drop counter
module cfs_rx_ctrl #(
  parameter  int ALGN_DATA_WIDTH       = 32,
  parameter  int STATUS_CNT_DROP_WIDTH = 8,
  localparam int ALGN_OFFSET_WIDTH     = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_DATA_WIDTH / 8),
  localparam int ALGN_SIZE_WIDTH       = $clog2(ALGN_DATA_WIDTH / 8) + 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             md_rx_valid,
  input  logic [ALGN_DATA_WIDTH-1:0]       md_rx_data,
  input  logic [ALGN_OFFSET_WIDTH-1:0]     md_rx_offset,
  input  logic [ALGN_SIZE_WIDTH-1:0]       md_rx_size,
  output logic                             md_rx_ready,
  output logic                             md_rx_err,
  output logic                             push_valid,
  output logic [ALGN_DATA_WIDTH-1:0]       push_data,
  output logic [ALGN_OFFSET_WIDTH-1:0]     push_offset,
  output logic [ALGN_SIZE_WIDTH-1:0]       push_size,
  input  logic                             push_ready,
  input  logic                             ctrl_clr,
  output logic [STATUS_CNT_DROP_WIDTH-1:0] status_cnt_drop,
  output logic                             max_drop
);

  // One spare bit so B+offset and offset+size never truncate.
  localparam int LW = ALGN_SIZE_WIDTH + 1;
  localparam logic [LW-1:0] B_EXT = LW'(ALGN_DATA_WIDTH / 8);
  localparam logic [STATUS_CNT_DROP_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [STATUS_CNT_DROP_WIDTH-1:0] CNT_ONE = STATUS_CNT_DROP_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, PUSH, RESP} state_t;

  state_t                           state_q, state_d;
  logic                             ready_q, ready_d;
  logic                             err_q, err_d;
  logic                             pvalid_q, pvalid_d;
  logic [ALGN_DATA_WIDTH-1:0]       pdata_q, pdata_d;
  logic [ALGN_OFFSET_WIDTH-1:0]     poffset_q, poffset_d;
  logic [ALGN_SIZE_WIDTH-1:0]       psize_q, psize_d;
  logic [STATUS_CNT_DROP_WIDTH-1:0] cnt_q, cnt_d;

  logic [LW-1:0] off_ext, size_ext;
  logic          legal;
  logic          drop;

  assign off_ext  = LW'(md_rx_offset);
  assign size_ext = LW'(md_rx_size);

  always_comb begin
    legal = 1'b0;
    if (size_ext != '0) begin
      legal = (((B_EXT + off_ext) % size_ext) == '0) && ((off_ext + size_ext) <= B_EXT);
    end
  end

  always_comb begin
    state_d   = state_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    pvalid_d  = pvalid_q;
    pdata_d   = pdata_q;
    poffset_d = poffset_q;
    psize_d   = psize_q;
    drop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_rx_valid) begin
          if (legal) begin
            pvalid_d  = 1'b1;
            pdata_d   = md_rx_data;
            poffset_d = md_rx_offset;
            psize_d   = md_rx_size;
            state_d   = PUSH;
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            drop    = 1'b1;
            state_d = RESP;
          end
        end
      end
      PUSH: begin
        if (push_ready) begin
          pvalid_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Clear wins over a simultaneous drop.
    cnt_d = cnt_q;
    if (ctrl_clr) begin
      cnt_d = '0;
    end else if (drop && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      pvalid_q  <= 1'b0;
      pdata_q   <= '0;
      poffset_q <= '0;
      psize_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      pvalid_q  <= pvalid_d;
      pdata_q   <= pdata_d;
      poffset_q <= poffset_d;
      psize_q   <= psize_d;
      cnt_q     <= cnt_d;
    end
  end

  assign md_rx_ready     = ready_q;
  assign md_rx_err       = err_q;
  assign push_valid      = pvalid_q;
  assign push_data       = pdata_q;
  assign push_offset     = poffset_q;
  assign push_size       = psize_q;
  assign status_cnt_drop = cnt_q;
  assign max_drop        = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_cfs_rx_ctrl.sv
// tb/tb_cfs_rx_ctrl.sv - directed vector bench for cfs_rx_ctrl
module tb_cfs_rx_ctrl;

  logic        clk;
  logic        reset_n;
  logic        md_rx_valid;
  logic [31:0] md_rx_data;
  logic [1:0]  md_rx_offset;
  logic [2:0]  md_rx_size;
  logic        md_rx_ready;
  logic        md_rx_err;
  logic        push_valid;
  logic [31:0] push_data;
  logic [1:0]  push_offset;
  logic [2:0]  push_size;
  logic        push_ready;
  logic        ctrl_clr;
  logic [7:0]  status_cnt_drop;
  logic        max_drop;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  cfs_rx_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .md_rx_valid     (md_rx_valid),
    .md_rx_data      (md_rx_data),
    .md_rx_offset    (md_rx_offset),
    .md_rx_size      (md_rx_size),
    .md_rx_ready     (md_rx_ready),
    .md_rx_err       (md_rx_err),
    .push_valid      (push_valid),
    .push_data       (push_data),
    .push_offset     (push_offset),
    .push_size       (push_size),
    .push_ready      (push_ready),
    .ctrl_clr        (ctrl_clr),
    .status_cnt_drop (status_cnt_drop),
    .max_drop        (max_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  offset;
    logic [2:0]  size;
    logic        legal;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts and ends just after a negedge with the DUT idle; push_ready assumed 1.
  task automatic run_txn(input logic [31:0] d, input logic [1:0] o, input logic [2:0] s,
                         input logic legal);
    md_rx_valid  = 1'b1;
    md_rx_data   = d;
    md_rx_offset = o;
    md_rx_size   = s;
    @(posedge clk);
    @(negedge clk);
    md_rx_valid = 1'b0;
    md_rx_data  = ~d;
    if (legal) begin
      chk("push_valid", push_valid, 1);
      chk("push_data", push_data, d);
      chk("push_offset", push_offset, o);
      chk("push_size", push_size, s);
      chk("ready_during_push", md_rx_ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk("ok_ready", md_rx_ready, 1);
      chk("ok_err", md_rx_err, 0);
      chk("push_valid_off", push_valid, 0);
    end else begin
      if (exp_cnt != 255) exp_cnt++;
      chk("drop_ready", md_rx_ready, 1);
      chk("drop_err", md_rx_err, 1);
      chk("drop_no_push", push_valid, 0);
    end
    @(posedge clk);
    @(negedge clk);
    chk("ready_pulse_end", md_rx_ready, 0);
    chk("err_end", md_rx_err, 0);
    chk("cnt_drop", status_cnt_drop, exp_cnt);
    chk("max_drop", max_drop, exp_cnt == 255);
  endtask

  initial begin
    vecs[0] = '{32'hAABBCCDD, 2'd1, 3'd1, 1'b1, 8'd0};
    vecs[1] = '{32'h01020304, 2'd2, 3'd2, 1'b1, 8'd0};
    vecs[2] = '{32'hDEADBEEF, 2'd0, 3'd4, 1'b1, 8'd0};
    vecs[3] = '{32'h11111111, 2'd0, 3'd0, 1'b0, 8'd1};
    vecs[4] = '{32'h22222222, 2'd0, 3'd3, 1'b0, 8'd2};
    vecs[5] = '{32'h33333333, 2'd1, 3'd2, 1'b0, 8'd3};
    vecs[6] = '{32'h44444444, 2'd1, 3'd4, 1'b0, 8'd4};
    vecs[7] = '{32'h55555555, 2'd3, 3'd1, 1'b1, 8'd4};
    vecs[8] = '{32'h66666666, 2'd2, 3'd3, 1'b0, 8'd5};
    vecs[9] = '{32'h77777777, 2'd3, 3'd2, 1'b0, 8'd6};

    reset_n      = 1'b0;
    md_rx_valid  = 1'b0;
    md_rx_data   = '0;
    md_rx_offset = '0;
    md_rx_size   = '0;
    push_ready   = 1'b1;
    ctrl_clr     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", md_rx_ready, 0);
    chk("rst_err", md_rx_err, 0);
    chk("rst_push_valid", push_valid, 0);
    chk("rst_push_data", push_data, 0);
    chk("rst_cnt", status_cnt_drop, 0);
    chk("rst_max", max_drop, 0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_txn(vecs[i].data, vecs[i].offset, vecs[i].size, vecs[i].legal);
      chk("vec_cnt", status_cnt_drop, vecs[i].cnt);
    end

    // Backpressure: FIFO full for 5 cycles, inputs wiggle after capture.
    push_ready   = 1'b0;
    md_rx_valid  = 1'b1;
    md_rx_data   = 32'h11223344;
    md_rx_offset = 2'd0;
    md_rx_size   = 3'd4;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      md_rx_data   = $urandom;
      md_rx_offset = 2'd1;
      md_rx_size   = 3'd0;
      chk("bp_push_valid", push_valid, 1);
      chk("bp_push_data", push_data, 32'h11223344);
      chk("bp_push_size", push_size, 4);
      chk("bp_ready", md_rx_ready, 0);
    end
    md_rx_valid = 1'b0;
    push_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_done_ready", md_rx_ready, 1);
    chk("bp_done_err", md_rx_err, 0);
    chk("bp_done_pv", push_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_ready", md_rx_ready, 0);

    // Saturation
    for (int n = 0; n < 260; n++) run_txn(32'h0, 2'd0, 3'd0, 1'b0);
    chk("sat_cnt", status_cnt_drop, 255);
    chk("sat_max", max_drop, 1);
    ctrl_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ctrl_clr = 1'b0;
    exp_cnt  = 0;
    chk("clr_cnt", status_cnt_drop, 0);
    chk("clr_max", max_drop, 0);

    // Clear coinciding with a counted drop
    for (int n = 0; n < 7; n++) run_txn(32'h0, 2'd1, 3'd2, 1'b0);
    chk("pre_coll_cnt", status_cnt_drop, 7);
    md_rx_valid  = 1'b1;
    md_rx_offset = 2'd0;
    md_rx_size   = 3'd0;
    ctrl_clr     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ctrl_clr    = 1'b0;
    md_rx_valid = 1'b0;
    exp_cnt     = 0;
    chk("coll_cnt", status_cnt_drop, 0);
    chk("coll_ready", md_rx_ready, 1);
    chk("coll_err", md_rx_err, 1);
    @(posedge clk);
    @(negedge clk);
    chk("coll_idle", md_rx_ready, 0);

    // Reset while stalled in PUSH
    run_txn(32'h0, 2'd0, 3'd3, 1'b0);
    push_ready   = 1'b0;
    md_rx_valid  = 1'b1;
    md_rx_data   = 32'hCAFEF00D;
    md_rx_offset = 2'd0;
    md_rx_size   = 3'd4;
    @(posedge clk);
    @(negedge clk);
    md_rx_valid = 1'b0;
    chk("pre_rst_pv", push_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pv", push_valid, 0);
    chk("arst_data", push_data, 0);
    chk("arst_ready", md_rx_ready, 0);
    chk("arst_err", md_rx_err, 0);
    chk("arst_cnt", status_cnt_drop, 0);
    @(negedge clk);
    reset_n    = 1'b1;
    push_ready = 1'b1;
    exp_cnt    = 0;
    @(negedge clk);
    chk("post_rst_pv", push_valid, 0);
    run_txn(32'h0BADCAFE, 2'd2, 3'd2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfs_rx_ctrl.md
Name: cfs_rx_ctrl

Overview:
- Aligner RX-side controller. Sits between the MD RX slave interface and the RX FIFO, downstream of the register block.
- Checks each incoming MD transaction (data, offset, size) for legality.
- Legal transactions are pushed into the RX FIFO; illegal ones are dropped and answered with an error.
- Maintains the saturating drop counter and max-drop flag that the register block reports as STATUS.CNT_DROP and uses for the MAX_DROP interrupt.

Parameters:
ALGN_DATA_WIDTH, 32, MD data width in bits; ALGN_DATA_WIDTH/8 is the byte count B.
STATUS_CNT_DROP_WIDTH, 8, width of the drop counter.
ALGN_OFFSET_WIDTH (localparam), ALGN_DATA_WIDTH<=8 ? 1 : $clog2(ALGN_DATA_WIDTH/8), offset field width.
ALGN_SIZE_WIDTH (localparam), $clog2(ALGN_DATA_WIDTH/8)+1, size field width.

Ports:
clk  in  1  clock; all state updates on posedge.
reset_n  in  1  asynchronous active-low reset.
md_rx_valid  in  1  MD master presents a transaction.
md_rx_data  in  ALGN_DATA_WIDTH  MD data.
md_rx_offset  in  ALGN_OFFSET_WIDTH  byte offset of valid data.
md_rx_size  in  ALGN_SIZE_WIDTH  number of valid bytes.
md_rx_ready  out  1  one-cycle transaction-complete pulse.
md_rx_err  out  1  error response; meaningful only while md_rx_ready=1, else 0.
push_valid  out  1  RX FIFO push request.
push_data  out  ALGN_DATA_WIDTH  captured data.
push_offset  out  ALGN_OFFSET_WIDTH  captured offset.
push_size  out  ALGN_SIZE_WIDTH  captured size.
push_ready  in  1  RX FIFO can accept (not full).
ctrl_clr  in  1  single-cycle pulse from the register block; clears the drop counter.
status_cnt_drop  out  STATUS_CNT_DROP_WIDTH  drop counter value.
max_drop  out  1  1 when status_cnt_drop equals all-ones.

Behaviour:

Reset values:
- State = IDLE.
- md_rx_ready=0, md_rx_err=0, push_valid=0.
- push_data/offset/size=0.
- status_cnt_drop=0, max_drop=0.
- Reset asserted mid-transaction aborts it: no push, no response, counter cleared.

Legality (combinational on md_rx_* inputs), legal if and only if all hold:
- size != 0
- (B + offset) % size == 0
- offset + size <= B
- Arithmetic is evaluated at least ALGN_SIZE_WIDTH+1 bits wide; there is no truncation on offset+size.

FSM:
- IDLE:
  - md_rx_valid=0: stay in IDLE.
  - md_rx_valid=1 and illegal: go to RESP with md_rx_ready<=1, md_rx_err<=1; counter increments at the same edge.
  - md_rx_valid=1 and legal: capture data/offset/size into push_*, push_valid<=1, go to PUSH.
- PUSH:
  - push_valid stays 1 and push_* stay stable until push_ready=1 is sampled.
  - On that edge: push_valid<=0, md_rx_ready<=1, md_rx_err<=0, go to RESP.
  - Waits indefinitely while the FIFO is full.
- RESP:
  - md_rx_ready and md_rx_err are held for exactly one cycle, then cleared; go to IDLE.
  - md_rx_* inputs are ignored in RESP.

Timing and handshake rules:
- md_rx_* changes after capture (PUSH/RESP) have no effect.
- Latency, illegal transaction: ready is high in the cycle after the valid sample edge.
- Latency, legal transaction with push_ready=1: push happens 1 cycle after acceptance; ready is high in the following cycle.
- Back-to-back transactions: a new transaction is sampled in IDLE, i.e. at the earliest one cycle after the ready pulse.
- md_rx_ready is a registered output.

Drop counter:
- Increments by 1 per dropped transaction.
- Saturates at 2^STATUS_CNT_DROP_WIDTH-1 and does not wrap.
- max_drop is decoded from the counter register.
- ctrl_clr=1 sets the counter to 0 at the next edge, including when a drop occurs at the same edge (clear wins; the drop is lost).
- ctrl_clr does not affect FSM state.

Test Plan (ALGN_DATA_WIDTH=32, B=4, CNT width 8):
1. Legal transactions:
   - Stimulus: data=0xAABBCCDD, offset=1, size=1, push_ready=1.
   - Required response: push_valid for 1 cycle with push_data=0xAABBCCDD/offset 1/size 1, then md_rx_ready=1, err=0; cnt_drop stays 0.
   - Repeat with (2,2) and (0,4): both accepted.
2. Illegal combinations:
   - Stimulus: (offset,size) = (0,0), (0,3), (1,2), (1,4), each sent in turn.
   - Required response: each gets md_rx_ready=1, err=1 one cycle after sampling; push_valid never asserted; cnt_drop ends at 4.
3. FIFO backpressure:
   - Stimulus: legal (0,4) transaction with push_ready=0 for 5 cycles.
   - Required response: push_valid=1 and push_* stable throughout; md_rx_ready stays 0.
   - Then push_ready=1: push completes, next cycle ready=1, err=0.
4. Saturation:
   - Stimulus: 260 illegal transactions.
   - Required response: cnt_drop=255 with max_drop=1 from the 255th drop on, no wrap.
   - Then ctrl_clr pulse: cnt_drop=0, max_drop=0.
5. Clear/drop collision:
   - Stimulus: cnt_drop=7; ctrl_clr coincides with the edge a drop is counted.
   - Required response: cnt_drop=0 after that edge, err response still issued.
6. Reset mid-operation:
   - Stimulus: reset_n low while in PUSH with push_ready=0.
   - Required response: all outputs 0 immediately (asynchronously).
   - After release, FSM in IDLE and the next legal transaction completes normally.
